// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller and the 128x8 single-port memory it drives.
package mem_fifo_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  // Occupancy value at which the memory holds DEPTH entries.
  localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(DEPTH);

endpackage

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a single-port synchronous memory with a
// 1-cycle registered read. Memory plus one output holding register gives
// DEPTH+1 words of storage. Reads take the memory slot ahead of writes
// because the memory ignores wen while ren is high.
module mem_fifo_ctrl
  import mem_fifo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              rd_pending_q, rd_pending_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic rd_go;
  logic wr_go;

  // Memory-port arbitration: a read is issued only when the output slot and
  // the read pipeline are both free; writes take whatever slots remain.
  always_comb begin
    rd_go    = (mem_cnt_q != '0) && !rd_pending_q && !out_valid_q;
    in_ready = rst_n && (mem_cnt_q < MEM_FULL) && !rd_go;
    wr_go    = in_valid && in_ready;
    mem_ren  = rst_n && rd_go;
    mem_wen  = wr_go;
    mem_addr = rd_go ? rd_ptr_q : wr_ptr_q;
    mem_din  = in_data;
  end

  // Next-state: pointer/count bookkeeping, read capture and pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    rd_pending_d = rd_pending_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;

    if (rd_go) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      mem_cnt_d    = mem_cnt_q - 1'b1;
      rd_pending_d = 1'b1;
    end else if (wr_go) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      mem_cnt_d = mem_cnt_q + 1'b1;
    end

    // rd_pending and out_valid are never high together, so capture and pop
    // cannot collide.
    if (rd_pending_q) begin
      out_data_d   = mem_dout;
      out_valid_d  = 1'b1;
      rd_pending_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset; an in-flight read is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      rd_pending_q <= rd_pending_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Status outputs: occupancy counts the word in flight and the output slot.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    count     = mem_cnt_q + CNT_W'(rd_pending_q) + CNT_W'(out_valid_q);
    full      = (mem_cnt_q == MEM_FULL);
    empty     = (count == '0);
  end

endmodule
